// File: rtl/cmd_scheduler.sv
// Command scheduler: merges UART command bytes and button edges into a 4-entry FIFO and
// replays each command on cmd_o for HOLD_CYCLES cycles followed by a GAP_CYCLES quiet gap.
module cmd_scheduler #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_valid_i,
    input  logic [7:0] uart_data_i,
    input  logic [5:0] btn_i,
    output logic [7:0] cmd_o,
    output logic       busy_o,
    output logic [2:0] level_o,
    output logic [7:0] drop_count_o
);

    localparam int unsigned DEPTH = 4;
    localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GapLoad  = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  fifo_q [DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  level_q, level_d;
    logic [5:0]  pend_q, pend_d;
    logic [5:0]  btn_prev_q;
    logic [7:0]  drop_q, drop_d;

    logic        pop, push, can_push, uart_legal;
    logic [7:0]  push_data;
    logic [5:0]  pend_all;

    function automatic logic is_legal(input logic [7:0] b);
        return (b == 8'h65) || (b == 8'h70) || (b == 8'h62) ||
               (b == 8'h73) || (b == 8'h74) || (b == 8'h77);
    endfunction

    function automatic logic [7:0] btn_code(input logic [2:0] idx);
        logic [7:0] code;
        case (idx)
            3'd0:    code = 8'h65;
            3'd1:    code = 8'h70;
            3'd2:    code = 8'h62;
            3'd3:    code = 8'h73;
            3'd4:    code = 8'h74;
            3'd5:    code = 8'h77;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    // Rising edges join the pending set combinationally so a fresh edge can push this cycle.
    always_comb begin
        pop        = (state_q == StIdle) && (level_q != 3'd0);
        can_push   = (level_q < 3'(DEPTH)) || pop;
        pend_all   = pend_q | (btn_i & ~btn_prev_q);
        uart_legal = uart_valid_i && is_legal(uart_data_i);
        push       = 1'b0;
        push_data  = 8'h00;
        pend_d     = pend_all;
        drop_d     = drop_q;
        if (uart_legal) begin
            if (can_push) begin
                push      = 1'b1;
                push_data = uart_data_i;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (can_push) begin
            for (int i = 0; i < 6; i++) begin
                if (pend_all[i] && !push) begin
                    push      = 1'b1;
                    push_data = btn_code(3'(i));
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    cmd_d   = fifo_q[rd_ptr_q];
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                end else begin
                    cmd_d = 8'h00;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    cmd_d   = 8'h00;
                    cnt_d   = GapLoad;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StGap: begin
                cmd_d = 8'h00;
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cmd_d   = 8'h00;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            cmd_q      <= 8'h00;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            level_q    <= 3'd0;
            pend_q     <= 6'd0;
            btn_prev_q <= 6'd0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pend_q     <= pend_d;
            btn_prev_q <= btn_i;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    assign cmd_o        = cmd_q;
    assign busy_o       = (state_q != StIdle);
    assign level_o      = level_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference model of the command stream.
module tb_cmd_scheduler;

    localparam int unsigned H = 4;
    localparam int unsigned G = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uv  = 1'b0;
    logic [7:0] ud  = 8'h00;
    logic [5:0] btn = 6'd0;
    logic [7:0] cmd;
    logic       busy;
    logic [2:0] level;
    logic [7:0] drop;

    always #5 clk = ~clk;

    cmd_scheduler #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .uart_valid_i (uv),
        .uart_data_i  (ud),
        .btn_i        (btn),
        .cmd_o        (cmd),
        .busy_o       (busy),
        .level_o      (level),
        .drop_count_o (drop)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a byte queue plus a countdown of remaining busy cycles.
    logic [7:0]  mq[$];
    logic [5:0]  m_pend;
    logic [5:0]  m_prev;
    int unsigned m_drop;
    int unsigned m_remain;
    logic [7:0]  m_cur;
    logic [7:0]  codes [6] = '{8'h65, 8'h70, 8'h62, 8'h73, 8'h74, 8'h77};

    function automatic logic [7:0] exp_cmd();
        return (m_remain > G) ? m_cur : 8'h00;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_pend   = 6'd0;
        m_prev   = 6'd0;
        m_drop   = 0;
        m_remain = 0;
        m_cur    = 8'h00;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d, input logic [5:0] b);
        logic       do_pop;
        logic       can_push;
        logic       legal;
        logic [5:0] pend;
        do_pop   = (m_remain == 0) && (mq.size() > 0);
        can_push = (mq.size() < 4) || do_pop;
        if (m_remain > 0) m_remain--;
        if (do_pop) begin
            m_cur    = mq.pop_front();
            m_remain = H + G;
        end
        pend   = m_pend | (b & ~m_prev);
        m_prev = b;
        legal  = 1'b0;
        for (int i = 0; i < 6; i++) if (codes[i] == d) legal = 1'b1;
        if (v && legal) begin
            if (can_push) mq.push_back(d);
            else if (m_drop < 255) m_drop++;
        end else if (can_push && pend != 6'd0) begin
            for (int i = 0; i < 6; i++) begin
                if (pend[i]) begin
                    mq.push_back(codes[i]);
                    pend[i] = 1'b0;
                    break;
                end
            end
        end
        m_pend = pend;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("cmd", 32'(cmd), 32'(exp_cmd()));
        chk("busy", 32'(busy), 32'(m_remain > 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("drop_count", 32'(drop), m_drop);
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic [5:0] b);
        uv  = v;
        ud  = d;
        btn = b;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(v, d, b);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         n2;
        logic [7:0] prev_cmd;
        logic [7:0] seq[$];
        logic       v;
        logic [7:0] d;
        logic [5:0] b;

        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Single UART command: two-edge latency, HOLD cycles of code, then idle.
        cycle(1'b1, 8'h65, 6'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 8'h00, 6'd0);
            if (i == 0) chk("latency", 32'(cmd), 32'h65);
            if (cmd == 8'h65) n++;
        end
        chk("hold_len", n, H);
        chk("idle_after", 32'(busy), 32'd0);

        // Illegal byte is ignored.
        cycle(1'b1, 8'h41, 6'd0);
        repeat (3) cycle(1'b0, 8'h00, 6'd0);
        chk("illegal_level", 32'(level), 32'd0);
        chk("illegal_drop", 32'(drop), 32'd0);

        // Six bytes during HOLD: four queue, two drop.
        cycle(1'b1, 8'h70, 6'd0);
        cycle(1'b0, 8'h00, 6'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, codes[i], 6'd0);
        chk("overflow_drop", 32'(drop), 32'd2);
        chk("overflow_level", 32'(level), 32'd4);

        // Full FIFO with a simultaneous pop accepts the new byte.
        while (m_remain != 0) cycle(1'b0, 8'h00, 6'd0);
        cycle(1'b1, 8'h77, 6'd0);
        chk("full_pop_level", 32'(level), 32'd4);
        chk("full_pop_drop", 32'(drop), 32'd2);
        repeat (60) cycle(1'b0, 8'h00, 6'd0);
        chk("drained", 32'(level), 32'd0);

        // UART beats both simultaneous button edges; buttons follow lowest index first.
        cycle(1'b1, 8'h74, 6'b001001);
        prev_cmd = cmd;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 8'h00, 6'b001001);
            if (cmd != 8'h00 && prev_cmd == 8'h00) seq.push_back(cmd);
            prev_cmd = cmd;
        end
        chk("order_count", seq.size(), 3);
        if (seq.size() == 3) begin
            chk("order0", 32'(seq[0]), 32'h74);
            chk("order1", 32'(seq[1]), 32'h65);
            chk("order2", 32'(seq[2]), 32'h73);
        end
        cycle(1'b0, 8'h00, 6'd0);

        // Asynchronous reset mid-HOLD, with btn[1] held through release.
        cycle(1'b0, 8'h00, 6'b000010);
        cycle(1'b0, 8'h00, 6'b000010);
        cycle(1'b1, 8'h65, 6'b000010);
        #2 rst = 1'b1;
        #1;
        chk("async_cmd", 32'(cmd), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        model_reset();
        cycle(1'b1, 8'h62, 6'b000010);
        cycle(1'b0, 8'h00, 6'b000010);
        rst = 1'b0;
        n  = 0;
        n2 = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00, 6'b000010);
            if (cmd == 8'h70) n++;
            if (cmd == 8'h65) n2++;
        end
        chk("held_btn_once", n, H);
        chk("discarded", n2, 0);

        // Random traffic against the model.
        b = 6'd0;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 255));
            else d = codes[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) b = b ^ 6'(1 << $urandom_range(0, 5));
            cycle(v, d, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, clock cycles a command byte is driven on cmd (legal range 1-15).
REQ-002 Parameter GAP_CYCLES, default 4, clock cycles cmd is held at 8'h00 after each command (legal range 1-15).
REQ-003 Parameter DEPTH, fixed at 4, command FIFO entries.
REQ-004 clk  input  1  system clock; the block uses one clock.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 uart_valid  input  1  one-cycle strobe: uart_data holds a received byte.
REQ-007 uart_data  input  8  received ASCII byte.
REQ-008 btn  input  6  debounced buttons, level; bit0..5 = 'e','p','b','s','t','w'.
REQ-009 cmd  output   8  command byte to stats inputs; 8'h00 = no command.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 level  output  3  FIFO occupancy, 0..4.
REQ-012 drop_count  output  8  UART bytes lost to a full FIFO, saturating at 255.

Function
REQ-013 Legal codes: 8'h65, 8'h70, 8'h62, 8'h73, 8'h74, 8'h77; a UART byte with any other value is ignored with no count.
REQ-014 Button rising edge (btn[i]=1, previous-cycle sample=0) sets pending[i]; an edge on an already-set bit merges.
REQ-015 At most one FIFO push per cycle; priority: legal UART byte first, then the lowest-index set pending bit.
REQ-016 A pending bit clears in the cycle its code is pushed; it stays set while it loses arbitration or while the FIFO is full.
REQ-017 A legal UART byte arriving while no push is possible is dropped, and drop_count increments, holding at 8'hFF.
REQ-018 Push is possible when level<4, or when level==4 and a pop occurs in the same cycle.
REQ-019 FIFO is first-in first-out; level updates +1 on push only, -1 on pop only, unchanged on both.
REQ-020 FSM states are IDLE, HOLD and GAP.
REQ-021 IDLE: if level>0, pop the head, register cmd<=head, load counter HOLD_CYCLES-1 and go to HOLD; otherwise stay with cmd=8'h00.
REQ-022 HOLD: cmd stays constant; at counter 0, set cmd<=8'h00, load GAP_CYCLES-1 and go to GAP; otherwise decrement.
REQ-023 GAP: cmd=8'h00; at counter 0 go to IDLE; otherwise decrement.
REQ-024 Each command therefore shows exactly HOLD_CYCLES cycles of code followed by at least GAP_CYCLES cycles of 8'h00, so the downstream one-shot guard re-arms.
REQ-025 Latency: a legal uart_valid at edge N into an empty FIFO with the FSM in IDLE drives cmd after edge N+2; the same applies to a button edge with no UART contention.
REQ-026 A push into an empty FIFO in the cycle the FSM returns to IDLE is not bypassed; the pop happens on the following edge.
REQ-027 Incoming pushes continue during HOLD and GAP; only pops are gated.

Reset
REQ-028 On reset assertion, cmd=8'h00, busy=0, level=0, drop_count=0, FSM=IDLE, counter=0, pending=0 and button history=0, all asynchronously.
REQ-029 Reset asserted mid-HOLD forces cmd to 8'h00 immediately and discards FIFO contents.
REQ-030 A button held through reset release produces exactly one command.
REQ-031 Inputs are ignored while reset is high.

Verification
REQ-032 Single UART 8'h65 strobe, idle, defaults -> cmd=8'h65 for exactly 4 cycles starting 2 cycles later, then 8'h00 for 4 cycles, busy=0 after, level back to 0.
REQ-033 uart_valid with 8'h41 -> no push, level=0, drop_count=0, cmd stays 8'h00.
REQ-034 Six back-to-back legal UART bytes while the FSM is in HOLD, FIFO not popping -> 4 queued, drop_count=2, output order matches arrival.
REQ-035 btn bits 0 and 3 rise together with a UART 8'h74 in the same cycle -> push order 8'h74, 8'h65, 8'h73; cmd shows the same sequence, each gap-separated.
REQ-036 level=4 with a pop occurring and a UART 8'h77 the same cycle -> 8'h77 accepted, level stays 4, drop_count unchanged.
REQ-037 Reset pulsed during HOLD of 8'h70 -> cmd=8'h00 without waiting for clk, level=0; after release the held btn[1] yields a single 8'h70.
